// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch path.
//   NOP_INSTR    - instruction returned in place of RAM data for out-of-range fetches
//   fetch_resp_t - address-tagged response record (default 32-bit layout)
//   count_t      - occupancy counter type for the default response FIFO depth
package fetch_pkg;

  localparam int ADDR_W         = 32;
  localparam int INSTR_W        = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } fetch_resp_t;

  typedef logic [$clog2(FIFO_DEPTH_DEF+1)-1:0] count_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered storage.
//   clk, rst   - clock, synchronous active-high reset (also zeroes storage)
//   clear      - drop all contents (pointers and count to 0, storage kept)
//   push       - write push_data at the tail (caller guarantees not full)
//   pop        - advance the head (caller guarantees not empty)
//   count      - current occupancy, 0..DEPTH
//   head       - entry at the head, valid when count != 0
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Zeroed so the head reads as all-zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: instruction-memory responder on the fetch path.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - fetch request handshake, word address on req_addr
//   flush                 - branch redirect: discard everything in flight
//   resp_valid/resp_ready - response handshake; resp_addr/resp_instr/resp_fault
//                           come from the head of the response FIFO
//   wr_en/wr_addr/wr_data - program-load write port into the instruction RAM
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid && ready are both high; the producer holds its payload stable while
// valid is high and ready is low. req_ready depends only on registered state
// plus rst/flush, never on resp_ready.
//
// Pipeline: accept (S1 registers address + RAM read) -> S2 push into FIFO.
// Latency from accept to resp_valid is two cycles.
module imem_fetch_resp
  import fetch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_addr,
  output logic [DATA_WIDTH-1:0]    resp_instr,
  output logic                     resp_fault,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = WIDTH + DATA_WIDTH + 1;

  logic                  req_fire;
  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_addr;
  logic                  s1_fault;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] s2_instr;
  logic [EW-1:0]         push_data;
  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;
  logic                  pop;

  // Occupancy counts the S1 entry as already owning a FIFO slot, so S2 can
  // always push without checking for room.
  assign occupancy = {1'b0, count} + (CW+1)'(s1_valid);
  assign req_ready = !rst && !flush && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;

  // Stage S1: capture the request and its range check.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_fault <= 1'b0;
    end else begin
      s1_valid <= req_fire;
      if (req_fire) begin
        s1_addr  <= req_addr;
        s1_fault <= (req_addr >= WIDTH'(DEPTH));
      end
    end
  end

  // Synchronous-read RAM. A read and write to the same word in one cycle
  // returns the old contents (read samples before the write lands).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    if (req_fire) begin
      ram_q <= ram[req_addr[AW-1:0]];
    end
  end

  // Stage S2: out-of-range fetches return a NOP instead of aliased RAM data.
  assign s2_instr  = s1_fault ? DATA_WIDTH'(NOP_INSTR) : ram_q;
  assign push_data = {s1_addr, s2_instr, s1_fault};

  // rst also masks resp_valid so nothing is consumed while resetting,
  // matching the flush behaviour.
  assign resp_valid = (count != '0) && !flush && !rst;
  assign pop        = resp_valid && resp_ready;

  sync_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (s1_valid),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign resp_addr  = head[EW-1 -: WIDTH];
  assign resp_instr = head[DATA_WIDTH:1];
  assign resp_fault = head[0];

endmodule

// File: doc/imem_fetch_resp.md
# imem_fetch_resp

Instruction-memory responder on the fetch path: accepts word addresses from the program counter over a valid/ready request channel, reads a synchronous instruction RAM, and returns address-tagged instructions to decode over a valid/ready response channel. A small output FIFO absorbs decode back-pressure at full throughput. A flush input discards all in-flight and buffered fetches when the pipeline redirects on a branch.

## Interface
- WIDTH, 32, address width; matches the PC output width (word address, PC increments by 1 per instruction)
- DATA_WIDTH, 32, instruction width
- DEPTH, 256, instruction RAM depth in words (power of 2)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, ≥3)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  PC presents a fetch address
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  WIDTH  word address to fetch
- flush  input  1  branch redirect; discard everything in flight
- resp_valid  output  1  response entry available
- resp_ready  input  1  decode consumes entry when resp_valid && resp_ready
- resp_addr  output  WIDTH  address of the returned instruction
- resp_instr  output  DATA_WIDTH  instruction word
- resp_fault  output  1  address was out of range
- wr_en  input  1  program-load write strobe
- wr_addr  input  $clog2(DEPTH)  program-load word address
- wr_data  input  DATA_WIDTH  program-load data

## Operation
- Stage S1: on an accepted request, register s1_valid=1, s1_addr=req_addr and s1_fault=(req_addr >= DEPTH), and issue the synchronous RAM read at index req_addr[$clog2(DEPTH)-1:0].
- Stage S2: when s1_valid is set, push {s1_addr, ram_q, s1_fault} into the FIFO. On fault, push instr = NOP (32'h0000_0013) instead of ram_q.
- req_ready = !rst && !flush && (count + s1_valid < FIFO_DEPTH). It depends only on registered state, with no combinational path from resp_ready. This guarantees the S1 entry always has FIFO room.
- resp_valid = (count != 0) && !flush. resp_* are driven from the FIFO head.
- Push and pop in the same cycle leave count unchanged and advance both pointers.
- flush: at the next edge, clear s1_valid and set count, rd_ptr and wr_ptr to 0.
  - A request presented during flush is not accepted.
  - No pop occurs during flush.
  - The first post-redirect address is accepted from the next cycle onward.
- flush and rst asserted together have the same effect as rst.
- RAM write: wr_en writes wr_data at the edge. Same-address read during write returns the old data. Writes do not interact with flush or reset.
- Reset values:
  - s1_valid=0, count=0, pointers 0.
  - resp_valid=0, resp_addr=0, resp_instr=0, resp_fault=0. The head entry is zeroed on reset.
  - req_ready=0 during rst and 1 the cycle after.
  - RAM contents are not reset.
- Reset mid-operation discards all fetches, exactly like flush.

## Timing
- Request accepted at cycle t: S1 is valid in t+1, and resp_valid is visible at t+2 (latency 2).
- With resp_ready held high and req_valid continuous: one response per cycle, with no bubbles after the initial 2-cycle fill.
- With resp_ready low, at most FIFO_DEPTH−1 further requests are accepted. req_ready then falls once count + s1_valid reaches FIFO_DEPTH.
- resp_* stay stable while resp_valid && !resp_ready (flush excepted).

## Structure
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013
  - fetch_resp_t struct {addr, instr, fault}
  - typedef for the count width, $clog2(FIFO_DEPTH+1)
- Sub-module sync_fifo: parameterized width/depth, push/pop/clear, count output, head output, registered storage. Reused elsewhere in the pipeline.
- The RAM is inferred inline as a single synchronous-read array.

## Test plan
- Reset: assert rst 2 cycles with req_valid=1 → req_ready=0, resp_valid=0, all resp_* = 0. req_ready=1 the cycle after release.
- Streaming: preload mem[0..7]=0x100+i, issue addresses 0..7 back-to-back with resp_ready=1 → responses addr 0..7, instr 0x100..0x107, consecutive cycles starting 2 cycles after the first accept.
- Back-pressure: resp_ready=0 with continuous requests → exactly 4 accepts total, req_ready low. Then resp_ready=1 → 4 in-order responses, with no loss or duplication.
- Flush: 3 entries buffered plus 1 in S1, pulse flush with req_valid=1 addr 9 → that request is not accepted and the next cycle has resp_valid=0. Issue addr 20 → only addr 20 is returned, at latency 2.
- Fault: request addr 256 (DEPTH=256) → resp_fault=1, resp_instr=0x0000_0013, resp_addr=256.
- Write/read collision: mem[5]=A, write B to 5 in the same cycle a request for 5 is accepted → response A. A later request for 5 → response B.
